// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stall_ctrl
// Description : Pipeline hazard controller. Arbitrates between HALT, data
//               memory wait, taken-branch flush and load-use interlock, and
//               drives the PC / IF/ID / ID/EX / EX/MEM hold, bubble and
//               squash controls.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   Id_rs_sel, Id_rt_sel       [2:0] decode-stage source registers
//   Id_rs_valid, Id_rt_valid   decode instruction really reads rs / rt
//   Ex_wr_sel                  [2:0] execute-stage destination register
//   Ex_MemRead, Ex_RegWrite    execute instruction is a load / writes a reg
//   Branch_taken               execute resolved a taken branch/jump/RegToPc
//   Dmem_busy                  data memory access not yet complete
//   Halt_ex                    HALT instruction in execute
//   Pc_stall, Ifid_stall       hold PC and IF/ID
//   Idex_bubble                load NOP control into ID/EX
//   Ifid_flush, Idex_flush     squash IF/ID and ID/EX
//   Exmem_stall                hold EX/MEM and MEM/WB, suppress writeback
//   Halted                     pipeline frozen by HALT
//   Stall_cycles               [15:0] saturating stall-cycle counter
//
// Build option : STALL_PERF_CNT_EN - when defined, Stall_cycles counts every
//                non-HALT cycle with Pc_stall=1 (saturating). When undefined,
//                Stall_cycles is tied to zero and no counter is built.
//
// Revision    : 1.0 - initial release
// ============================================================================
module stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  Id_rs_sel,
    input  logic [2:0]  Id_rt_sel,
    input  logic        Id_rs_valid,
    input  logic        Id_rt_valid,
    input  logic [2:0]  Ex_wr_sel,
    input  logic        Ex_MemRead,
    input  logic        Ex_RegWrite,
    input  logic        Branch_taken,
    input  logic        Dmem_busy,
    input  logic        Halt_ex,
    output logic        Pc_stall,
    output logic        Ifid_stall,
    output logic        Idex_bubble,
    output logic        Ifid_flush,
    output logic        Idex_flush,
    output logic        Exmem_stall,
    output logic        Halted,
    output logic [15:0] Stall_cycles
);

    localparam logic [1:0] c_ST_RUN       = 2'd0;
    localparam logic [1:0] c_ST_DMEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_FLUSH     = 2'd2;
    localparam logic [1:0] c_ST_HALT      = 2'd3;

    logic [1:0] r_state;
    logic       r_pend_flush;

    logic [1:0] w_next_state;
    logic       w_set_pend;
    logic       w_clr_pend;
    logic       w_load_use;

    assign w_load_use = Ex_MemRead & Ex_RegWrite &
                        ((Id_rs_valid & (Id_rs_sel == Ex_wr_sel)) |
                         (Id_rt_valid & (Id_rt_sel == Ex_wr_sel)));

    // Priority chain: HALT state / Halt_ex, then memory wait, then the
    // second squash cycle of a flush, then a new or deferred flush, then
    // the load-use interlock.
    always_comb begin
        Pc_stall     = 1'b0;
        Ifid_stall   = 1'b0;
        Idex_bubble  = 1'b0;
        Ifid_flush   = 1'b0;
        Idex_flush   = 1'b0;
        Exmem_stall  = 1'b0;
        Halted       = 1'b0;
        w_next_state = r_state;
        w_set_pend   = 1'b0;
        w_clr_pend   = 1'b0;

        if (rst) begin
            // Outputs held low while in reset; state is cleared on the edge.
            w_next_state = c_ST_RUN;
        end else if (r_state == c_ST_HALT) begin
            Pc_stall    = 1'b1;
            Ifid_stall  = 1'b1;
            Exmem_stall = 1'b1;
            Halted      = 1'b1;
        end else if (Halt_ex) begin
            // Freeze immediately; Halted follows once the state is entered.
            Pc_stall     = 1'b1;
            Ifid_stall   = 1'b1;
            Exmem_stall  = 1'b1;
            w_next_state = c_ST_HALT;
        end else if (Dmem_busy) begin
            // Whole pipe holds; a branch resolved now is remembered so its
            // flush is issued once memory completes.
            Pc_stall     = 1'b1;
            Ifid_stall   = 1'b1;
            Exmem_stall  = 1'b1;
            w_next_state = c_ST_DMEM_WAIT;
            w_set_pend   = Branch_taken;
        end else if (r_state == c_ST_FLUSH) begin
            // Kill the wrong-path fetch that was in flight during the flush.
            Ifid_flush   = 1'b1;
            w_next_state = c_ST_RUN;
        end else if (Branch_taken || r_pend_flush) begin
            Ifid_flush   = 1'b1;
            Idex_flush   = 1'b1;
            w_next_state = c_ST_FLUSH;
            w_clr_pend   = 1'b1;
        end else begin
            w_next_state = c_ST_RUN;
            if (w_load_use) begin
                Pc_stall    = 1'b1;
                Ifid_stall  = 1'b1;
                Idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_RUN;
            r_pend_flush <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_set_pend) begin
                r_pend_flush <= 1'b1;
            end else if (w_clr_pend) begin
                r_pend_flush <= 1'b0;
            end
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [15:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 16'h0000;
        end else if (Pc_stall && (r_state != c_ST_HALT) &&
                     (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'h0001;
        end
    end

    assign Stall_cycles = r_stall_cycles;
`else
    assign Stall_cycles = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 clk  input  1  system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 Id_rs_sel / Id_rt_sel  input  3 each  source registers of the instruction in decode.
REQ-005 Id_rs_valid / Id_rt_valid  input  1 each  decode instruction actually reads rs / rt.
REQ-006 Ex_wr_sel  input  3  destination register of the instruction in execute.
REQ-007 Ex_MemRead / Ex_RegWrite  input  1 each  execute instruction is a load / writes a register.
REQ-008 Branch_taken  input  1  execute resolved a taken branch, jump or RegToPc.
REQ-009 Dmem_busy  input  1  data memory not done; the current memory access must be held.
REQ-010 Halt_ex  input  1  HALT instruction in execute.
REQ-011 Pc_stall, Ifid_stall  output  1 each  hold the PC and the IF/ID register.
REQ-012 Idex_bubble  output  1  load NOP control into ID/EX.
REQ-013 Ifid_flush, Idex_flush  output  1 each  squash the IF/ID and ID/EX contents.
REQ-014 Exmem_stall  output  1  hold EX/MEM and MEM/WB; suppress register writeback.
REQ-015 Halted  output  1  pipeline frozen by HALT.
REQ-016 Stall_cycles  output  16  stall performance count (see Configuration).

Function
REQ-017 The FSM SHALL use states RUN, DMEM_WAIT, FLUSH and HALT; outputs are combinational from state and inputs.
REQ-018 Load-use hazard SHALL be Ex_MemRead & Ex_RegWrite & ((Id_rs_valid & Id_rs_sel==Ex_wr_sel) | (Id_rt_valid & Id_rt_sel==Ex_wr_sel)).
REQ-019 RUN with load-use and no higher-priority event: Pc_stall=Ifid_stall=Idex_bubble=1 for exactly that cycle; state stays RUN.
REQ-020 RUN with Branch_taken and Dmem_busy=0: Ifid_flush=Idex_flush=1 that cycle; next state FLUSH; the load-use bubble is suppressed.
REQ-021 FLUSH: Ifid_flush=1 for one cycle, which squashes the in-flight fetch; next state RUN unless Dmem_busy or Halt_ex.
REQ-022 Any state except HALT with Dmem_busy=1: Pc_stall=Ifid_stall=Exmem_stall=1 and Idex_bubble=0; next state DMEM_WAIT.
REQ-023 DMEM_WAIT: hold all stages while Dmem_busy=1; on the first cycle Dmem_busy=0, return to RUN.
REQ-024 A Branch_taken that arrives while Dmem_busy=1 SHALL set a pending-flush flag; the flush of REQ-020 is issued on the first cycle Dmem_busy=0, and the flag clears then.
REQ-025 Halt_ex in any state SHALL cause HALT on the next cycle; HALT asserts Pc_stall=Ifid_stall=Exmem_stall=Halted=1 until rst.
REQ-026 Priority SHALL be: HALT/Halt_ex > Dmem_busy > Branch_taken/pending flush > load-use.
REQ-027 Flush and stall SHALL never both be asserted on the same register; flush wins at IF/ID.

Reset
REQ-028 While rst=1, all outputs SHALL be 0 and Stall_cycles SHALL be 0; state becomes RUN and the pending flag clears on the edge.
REQ-029 rst asserted during DMEM_WAIT, FLUSH or HALT SHALL abandon that state with no residual stall or flush afterwards.

Configuration
REQ-030 With STALL_PERF_CNT_EN defined, Stall_cycles SHALL increment on every cycle Pc_stall=1 outside HALT and saturate at 16'hFFFF.
REQ-031 Without STALL_PERF_CNT_EN, Stall_cycles SHALL be constant 16'h0000 and no counter flops are built.

Verification
REQ-032 Ex load to r3, Id_rs_sel=3, Id_rs_valid=1 -> one cycle of Pc_stall/Ifid_stall/Idex_bubble=1, then all 0.
REQ-033 Same as REQ-032 but Id_rs_valid=0, Id_rt_sel=3, Id_rt_valid=0 -> no stall.
REQ-034 Branch_taken for 1 cycle -> Ifid_flush=Idex_flush=1 in cycle 0, Ifid_flush only in cycle 1, then RUN.
REQ-035 Dmem_busy high for 4 cycles with Branch_taken in cycle 1 -> Exmem_stall=1 for 4 cycles, flush in cycle 4, FLUSH in cycle 5.
REQ-036 Halt_ex pulse, then 10 idle cycles, then rst -> Halted=1 for all 10 cycles, 0 after reset.
REQ-037 With STALL_PERF_CNT_EN, hold Dmem_busy=1 for 70000 cycles -> Stall_cycles=16'hFFFF without wrap.
